counter_scheduler: RTL and testbench
====================================

COUNTER_SCHEDULER -- requirements
Module: counter_scheduler

Interface
REQ-001 Parameter CNT_W, default 4: width of each requester's repeat-count field.
REQ-002 Clock  input  1  single clock; all state changes on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 ReqA  input  1  requester A request; held high until AckA.
REQ-005 OpA  input  2  requester A step code: 00 hold, 01 +1, 10 +2, 11 -1.
REQ-006 CntA  input  CNT_W  requester A repeat count.
REQ-007 AckA  output  1  one-cycle completion pulse to requester A.
REQ-008 ReqB, OpB, CntB, AckB: same as REQ-004 to REQ-007, for requester B.
REQ-009 Value  output  4  shared mod-10 digit, range 0..9.
REQ-010 Busy  output  1  high while a granted operation is in progress.
REQ-011 Grant  output  2  one-hot current owner: bit0 is A, bit1 is B; 00 when idle.
REQ-012 Wrap  output  1  one-cycle pulse after any step that crosses the 9/0 boundary.

Function
REQ-013 FSM states are IDLE, RUN and DONE; the encoding is defined in the package.
REQ-014 IDLE: if no Req is high, remain in IDLE.
REQ-015 IDLE: if any Req is high, grant one requester, latch its Op and Count, and go to RUN on the same edge.
REQ-016 Arbitration is round-robin on LastGrant; if only one Req is high, that requester wins.
REQ-017 If both Reqs are high, grant the requester that was not granted last.
REQ-018 LastGrant resets to B, so A wins the first tie.
REQ-019 A latched Count of 0 is treated as 1.
REQ-020 RUN: each cycle, apply the latched Op once to Value and decrement the remaining count.
REQ-021 RUN goes to DONE on the edge that applies the final step.
REQ-022 Op arithmetic is modulo 10:
  - +1: 9 goes to 0.
  - +2: 8 goes to 0, 9 goes to 1.
  - -1: 0 goes to 9.
  - hold: Value is unchanged but the step still consumes a cycle.
REQ-023 Wrap is registered and is high for exactly the cycle following each step whose result wrapped; hold never wraps.
REQ-024 DONE: assert Ack for the owner only, update LastGrant to the owner, and go to IDLE on the next edge.
REQ-025 Latency: with Req sampled at edge k, Value updates at edges k+1 through k+N (N is the effective count).
REQ-026 Latency: Ack is high in the cycle after edge k+N, so Ack follows the sampling edge by N+1 cycles.
REQ-027 Busy is high in RUN and DONE; Grant is driven in RUN and DONE; both are low in IDLE.
REQ-028 The requester must drop Req on the edge where its Ack is high.
REQ-029 A requester may reassert Req one cycle after Ack; the request is then arbitrated normally.
REQ-030 The losing requester's Req stays pending, unacknowledged, and is served next.
REQ-031 Op and Count are sampled only at grant; changes during RUN are ignored.
REQ-032 A Req deasserted during RUN does not abort the operation; Ack is still issued.
REQ-033 Only one requester is ever granted at a time, and Ack is never asserted outside DONE.

Reset
REQ-034 While Reset is high, at each edge set:
  - state IDLE, Value 0, LastGrant B, remaining count 0, Wrap 0;
  - AckA, AckB, Busy and Grant low.
REQ-035 Reset during RUN or DONE aborts the operation: no Ack is issued, and a held Req is re-arbitrated in the first IDLE cycle after Reset falls.
REQ-036 Reset has priority over every other transition in the same cycle.

Structure
REQ-037 Package counter_sched_pkg holds:
  - op code constants OP_HOLD, OP_INC1, OP_INC2, OP_DEC1;
  - constant MODULUS = 10;
  - state encoding constants S_IDLE, S_RUN, S_DONE.
REQ-038 Sub-module digit_step is purely combinational: (Value[3:0], Op[1:0]) -> (NextValue[3:0], WrapNext); it is instantiated once.
REQ-039 All other logic sits in counter_scheduler: FSM, arbiter, latched op and count, down-counter, and output registers.

Verification
REQ-040 After reset, ReqA with Op 01 and Cnt 3: Value goes 1, 2, 3 on consecutive edges; AckA pulses once, 4 cycles after the grant edge; Grant is 01 throughout.
REQ-041 Value 8, ReqB with Op 10 and Cnt 1: Value becomes 0 and Wrap pulses one cycle. Then Op 11 and Cnt 1 from 0: Value becomes 9 and Wrap pulses.
REQ-042 ReqA and ReqB both high from reset, each Cnt 2: A is served first, then B, then A again while both are held; AckA and AckB are never high together.
REQ-043 Cnt 0 with Op 01 from Value 5: exactly one step to 6; Ack arrives 2 cycles after the grant edge.
REQ-044 Reset pulsed mid-RUN of Cnt 5: Value is 0, no Ack, Busy low; with Req still held, a new grant occurs in the first cycle after Reset falls.
REQ-045 Op 00 with Cnt 4 from Value 7: Value stays 7, Busy is high for 5 cycles, Wrap never asserts, and Ack is issued.

Source files
------------

// File: rtl/counter_sched_pkg.sv
// Shared constants for the counter scheduler: op codes, digit range, owner ids, FSM encoding.
package counter_sched_pkg;

  // Step codes carried on OpA / OpB
  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_INC1 = 2'b01;
  localparam logic [1:0] OP_INC2 = 2'b10;
  localparam logic [1:0] OP_DEC1 = 2'b11;

  // The shared digit counts modulo 10
  localparam int         MODULUS   = 10;
  localparam logic [3:0] DIGIT_MAX = 4'(MODULUS - 1);

  // Owner / last-grant identifiers
  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  // Scheduler FSM encoding
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/digit_step.sv
// Combinational mod-10 step: applies one op code to a digit and flags a 9/0 crossing.
module digit_step
  import counter_sched_pkg::*;
(
  input  logic [3:0] Value,
  input  logic [1:0] Op,
  output logic [3:0] NextValue,
  output logic       WrapNext
);

  // One step of modulo-10 arithmetic; hold passes the digit through and never wraps
  always_comb begin
    NextValue = Value;
    WrapNext  = 1'b0;
    case (Op)
      OP_INC1: begin
        if (Value >= DIGIT_MAX) begin
          NextValue = 4'd0;
          WrapNext  = 1'b1;
        end else begin
          NextValue = Value + 4'd1;
        end
      end
      OP_INC2: begin
        if (Value >= DIGIT_MAX - 4'd1) begin
          NextValue = Value - 4'(MODULUS - 2);
          WrapNext  = 1'b1;
        end else begin
          NextValue = Value + 4'd2;
        end
      end
      OP_DEC1: begin
        if (Value == 4'd0) begin
          NextValue = DIGIT_MAX;
          WrapNext  = 1'b1;
        end else begin
          NextValue = Value - 4'd1;
        end
      end
      default: begin
        NextValue = Value;
        WrapNext  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/counter_scheduler.sv
// Two-requester round-robin scheduler driving a shared mod-10 digit with repeated steps.
module counter_scheduler
  import counter_sched_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             ReqA,
  input  logic [1:0]       OpA,
  input  logic [CNT_W-1:0] CntA,
  output logic             AckA,
  input  logic             ReqB,
  input  logic [1:0]       OpB,
  input  logic [CNT_W-1:0] CntB,
  output logic             AckB,
  output logic [3:0]       Value,
  output logic             Busy,
  output logic [1:0]       Grant,
  output logic             Wrap
);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [3:0]       value_q, value_d;
  logic             wrap_q, wrap_d;
  logic             ack_a_q, ack_a_d;
  logic             ack_b_q, ack_b_d;
  logic             busy_q, busy_d;
  logic [1:0]       grant_q, grant_d;

  logic             pick_b;
  logic [CNT_W-1:0] sel_cnt;
  logic [3:0]       step_value;
  logic             step_wrap;

  digit_step u_digit_step (
    .Value     (value_q),
    .Op        (op_q),
    .NextValue (step_value),
    .WrapNext  (step_wrap)
  );

  // Next-state logic: arbitration in IDLE, stepping in RUN, handshake in DONE.
  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    remain_d     = remain_q;
    value_d      = value_q;
    wrap_d       = 1'b0;
    // B wins when it is alone, or on a tie when A was served last
    pick_b       = ReqB && !(ReqA && (last_grant_q == OWNER_B));
    sel_cnt      = pick_b ? CntB : CntA;

    case (state_q)
      S_IDLE: begin
        if (ReqA || ReqB) begin
          owner_d  = pick_b ? OWNER_B : OWNER_A;
          op_d     = pick_b ? OpB : OpA;
          // A zero repeat count still performs one step
          remain_d = (sel_cnt == '0) ? CNT_W'(1) : sel_cnt;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        value_d  = step_value;
        wrap_d   = step_wrap;
        remain_d = remain_q - CNT_W'(1);
        if (remain_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        last_grant_d = owner_q;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d  = (state_d != S_IDLE);
    grant_d = busy_d ? ((owner_d == OWNER_B) ? 2'b10 : 2'b01) : 2'b00;
    ack_a_d = (state_d == S_DONE) && (owner_d == OWNER_A);
    ack_b_d = (state_d == S_DONE) && (owner_d == OWNER_B);
  end

  // State and output registers; reset overrides everything else
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      owner_q      <= OWNER_A;
      last_grant_q <= OWNER_B;
      op_q         <= OP_HOLD;
      remain_q     <= '0;
      value_q      <= 4'd0;
      wrap_q       <= 1'b0;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      busy_q       <= 1'b0;
      grant_q      <= 2'b00;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      remain_q     <= remain_d;
      value_q      <= value_d;
      wrap_q       <= wrap_d;
      ack_a_q      <= ack_a_d;
      ack_b_q      <= ack_b_d;
      busy_q       <= busy_d;
      grant_q      <= grant_d;
    end
  end

  assign AckA  = ack_a_q;
  assign AckB  = ack_b_q;
  assign Value = value_q;
  assign Busy  = busy_q;
  assign Grant = grant_q;
  assign Wrap  = wrap_q;

endmodule

// File: tb/tb_counter_scheduler.sv
// Scoreboard bench for counter_scheduler: stimulus queues expected acks, a monitor checks them.
module tb_counter_scheduler;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       ReqA = 1'b0, ReqB = 1'b0;
  logic [1:0] OpA = 2'b00, OpB = 2'b00;
  logic [3:0] CntA = 4'd0, CntB = 4'd0;
  logic       AckA, AckB, Busy, Wrap;
  logic [3:0] Value;
  logic [1:0] Grant;

  counter_scheduler #(.CNT_W(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .ReqA  (ReqA),
    .OpA   (OpA),
    .CntA  (CntA),
    .AckA  (AckA),
    .ReqB  (ReqB),
    .OpB   (OpB),
    .CntB  (CntB),
    .AckB  (AckB),
    .Value (Value),
    .Busy  (Busy),
    .Grant (Grant),
    .Wrap  (Wrap)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    bit is_b;
    int value;
    int wraps;
  } sb_t;

  sb_t sb_q[$];
  int  pass_cnt  = 0;
  int  total_cnt = 0;
  int  model_val = 0;
  int  wrap_seen = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic int op_delta(input logic [1:0] op);
    case (op)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return -1;
      default: return 0;
    endcase
  endfunction

  // Monitor: count wrap pulses and check every Ack against the scoreboard
  always @(negedge Clock) begin
    if (Reset) begin
      wrap_seen = 0;
    end else begin
      if (Wrap) wrap_seen++;
      if (AckA || AckB) begin
        int qs;
        sb_t e;
        qs = sb_q.size();
        chk("ack_exclusive", int'(AckA && AckB), 0);
        chk("ack_expected", int'(qs != 0), 1);
        if (qs != 0) begin
          e = sb_q.pop_front();
          chk("ack_owner_b", int'(AckB), int'(e.is_b));
          chk("ack_grant", int'(Grant), e.is_b ? 2 : 1);
          chk("ack_value", int'(Value), e.value);
          chk("ack_wraps", wrap_seen, e.wraps);
          $display("ack %s value=%0d wraps=%0d", AckB ? "B" : "A", Value, wrap_seen);
        end
        wrap_seen = 0;
      end
    end
  end

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    chk("rst_value", int'(Value), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_grant", int'(Grant), 0);
    chk("rst_acka", int'(AckA), 0);
    chk("rst_ackb", int'(AckB), 0);
    chk("rst_wrap", int'(Wrap), 0);
    Reset = 1'b0;
    model_val = 0;
  endtask

  task automatic wait_ack(input string nm);
    int k;
    k = 0;
    while (!(AckA || AckB) && k < 30) begin
      tick();
      k++;
    end
    chk(nm, int'(AckA || AckB), 1);
  endtask

  // One request from an idle scheduler, checked step by step
  task automatic single_op(input bit is_b, input logic [1:0] op, input logic [3:0] cnt,
                           input int exp_final, input int exp_wraps, input bit drop_early);
    int n;
    int s;
    n = (cnt == 4'd0) ? 1 : int'(cnt);
    sb_q.push_back('{is_b, exp_final, exp_wraps});
    if (is_b) begin ReqB = 1'b1; OpB = op; CntB = cnt; end
    else      begin ReqA = 1'b1; OpA = op; CntA = cnt; end
    tick();
    chk("grant_run", int'(Grant), is_b ? 2 : 1);
    chk("busy_grant", int'(Busy), 1);
    chk("value_grant", int'(Value), model_val);
    // Changes after the grant must be ignored
    if (is_b) begin OpB = ~op; CntB = cnt + 4'd7; if (drop_early) ReqB = 1'b0; end
    else      begin OpA = ~op; CntA = cnt + 4'd7; if (drop_early) ReqA = 1'b0; end
    for (int i = 0; i < n; i++) begin
      tick();
      s = model_val + op_delta(op);
      model_val = (s + 10) % 10;
      chk("step_value", int'(Value), model_val);
      chk("step_wrap", int'(Wrap), int'(s > 9 || s < 0));
      chk("step_busy", int'(Busy), 1);
    end
    chk("done_ack", int'(is_b ? AckB : AckA), 1);
    ReqA = 1'b0;
    ReqB = 1'b0;
    tick();
    chk("idle_busy", int'(Busy), 0);
    chk("idle_grant", int'(Grant), 0);
    chk("idle_ack", int'(AckA || AckB), 0);
    $display("op %s code=%0d cnt=%0d -> value=%0d", is_b ? "B" : "A", op, cnt, Value);
  endtask

  initial begin
    do_reset();
    tick();

    // Directed single-requester sequence
    single_op(1'b0, 2'b01, 4'd3, 3, 0, 1'b0);  // 0 -> 1,2,3
    single_op(1'b0, 2'b01, 4'd5, 8, 0, 1'b0);  // 3 -> 8
    single_op(1'b1, 2'b10, 4'd1, 0, 1, 1'b0);  // 8 +2 -> 0, wraps
    single_op(1'b1, 2'b11, 4'd1, 9, 1, 1'b0);  // 0 -1 -> 9, wraps
    single_op(1'b0, 2'b10, 4'd3, 5, 1, 1'b0);  // 9 -> 1 -> 3 -> 5
    single_op(1'b0, 2'b01, 4'd0, 6, 0, 1'b0);  // count 0 acts as 1
    single_op(1'b1, 2'b01, 4'd1, 7, 0, 1'b1);  // Req dropped during RUN
    single_op(1'b1, 2'b00, 4'd4, 7, 0, 1'b0);  // hold x4

    // Round-robin with both requesters held from reset
    do_reset();
    ReqA = 1'b1; OpA = 2'b01; CntA = 4'd2;
    ReqB = 1'b1; OpB = 2'b01; CntB = 4'd2;
    sb_q.push_back('{1'b0, 2, 0});
    sb_q.push_back('{1'b1, 4, 0});
    sb_q.push_back('{1'b0, 6, 0});
    tick();
    chk("tie1_grant", int'(Grant), 1);
    wait_ack("tie1_timeout");
    ReqA = 1'b0;
    tick();
    ReqA = 1'b1;
    tick();
    chk("tie2_grant", int'(Grant), 2);
    wait_ack("tie2_timeout");
    ReqB = 1'b0;
    tick();
    tick();
    chk("rr3_grant", int'(Grant), 1);
    wait_ack("rr3_timeout");
    ReqA = 1'b0;
    tick();
    chk("rr_idle_busy", int'(Busy), 0);

    // Reset in the middle of a 5-step run
    do_reset();
    ReqA = 1'b1; OpA = 2'b01; CntA = 4'd5;
    tick();
    tick();
    tick();
    chk("mid_value", int'(Value), 2);
    Reset = 1'b1;
    tick();
    chk("abort_value", int'(Value), 0);
    chk("abort_busy", int'(Busy), 0);
    chk("abort_ack", int'(AckA), 0);
    chk("abort_grant", int'(Grant), 0);
    Reset = 1'b0;
    sb_q.push_back('{1'b0, 5, 0});
    tick();
    chk("regrant_grant", int'(Grant), 1);
    chk("regrant_busy", int'(Busy), 1);
    wait_ack("regrant_timeout");
    ReqA = 1'b0;
    tick();
    tick();

    chk("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
